// File: rtl/mem_access_if.sv
// Data-memory request/ack port between the mem_access stage and the data RAM.
// The stage is the master: it holds a registered request until the one-cycle ack.
interface mem_access_if;
  logic        dram_req;
  logic        dram_we;
  logic [31:0] dram_addr;
  logic [3:0]  dram_wstrb;
  logic [31:0] dram_wdata;
  logic        dram_ack;
  logic [31:0] dram_rdata;

  modport master (
    output dram_req,
    output dram_we,
    output dram_addr,
    output dram_wstrb,
    output dram_wdata,
    input  dram_ack,
    input  dram_rdata
  );

  modport slave (
    input  dram_req,
    input  dram_we,
    input  dram_addr,
    input  dram_wstrb,
    input  dram_wdata,
    output dram_ack,
    output dram_rdata
  );
endinterface

// File: rtl/mem_access.sv
// Memory-access stage: load/store/LL/SC over a req/ack data port with pipeline pause.
// Define MEM_LLSC_EN to enable LL_W/SC_W; otherwise they decode as NONE.
module mem_access (
  input  logic         clk,
  input  logic         rst,
  input  logic [5:0]   pause,
  input  logic         in_valid,
  input  logic [3:0]   mem_op,
  input  logic [31:0]  mem_addr,
  input  logic [31:0]  mem_store_data,
  input  logic [31:0]  ex_reg_write_data,
  input  logic [4:0]   ex_reg_write_addr,
  input  logic         ex_reg_write_en,
  input  logic         LLbit_i,
  mem_access_if.master dram,
  output logic         pause_request,
  output logic         align_error,
  output logic [31:0]  mem_reg_write_data,
  output logic [4:0]   mem_reg_write_addr,
  output logic         mem_reg_write_en,
  output logic         mem_LLbit_write_en,
  output logic         mem_LLbit_write_data
);

  localparam logic [3:0] OP_LDB  = 4'h1;
  localparam logic [3:0] OP_LDH  = 4'h2;
  localparam logic [3:0] OP_LDW  = 4'h3;
  localparam logic [3:0] OP_LDBU = 4'h4;
  localparam logic [3:0] OP_LDHU = 4'h5;
  localparam logic [3:0] OP_STB  = 4'h6;
  localparam logic [3:0] OP_STH  = 4'h7;
  localparam logic [3:0] OP_STW  = 4'h8;
  localparam logic [3:0] OP_LLW  = 4'h9;
  localparam logic [3:0] OP_SCW  = 4'hA;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic       ld, st, ll, sc, sx;
  logic [1:0] sz;
  logic       mis, misalign, start, sc_fail;

  logic       ld_q, st_q, ll_q, sc_q, sx_q;
  logic [1:0] sz_q;
  logic [1:0] off_q;
  logic [4:0] rd_q;
  logic [31:0] rdata_q;

  logic [31:0] shifted;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ld_data;

  logic [3:0]  wstrb_nxt;
  logic [31:0] wdata_nxt;

  logic unused_pause;
  assign unused_pause = ^{pause[5], pause[3:0]};

  always_comb begin
    ld = 1'b0;
    st = 1'b0;
    ll = 1'b0;
    sc = 1'b0;
    sx = 1'b0;
    sz = SZ_W;
    unique case (1'b1)
      (mem_op == OP_LDB):  begin ld = 1'b1; sz = SZ_B; sx = 1'b1; end
      (mem_op == OP_LDH):  begin ld = 1'b1; sz = SZ_H; sx = 1'b1; end
      (mem_op == OP_LDW):  begin ld = 1'b1; sz = SZ_W; end
      (mem_op == OP_LDBU): begin ld = 1'b1; sz = SZ_B; end
      (mem_op == OP_LDHU): begin ld = 1'b1; sz = SZ_H; end
      (mem_op == OP_STB):  begin st = 1'b1; sz = SZ_B; end
      (mem_op == OP_STH):  begin st = 1'b1; sz = SZ_H; end
      (mem_op == OP_STW):  begin st = 1'b1; sz = SZ_W; end
`ifdef MEM_LLSC_EN
      (mem_op == OP_LLW):  ll = 1'b1;
      (mem_op == OP_SCW):  sc = 1'b1;
`endif
      default: ;
    endcase
  end

  assign mis = ((sz == SZ_H) && mem_addr[0])
            || ((sz == SZ_W) && (mem_addr[1:0] != 2'b00));

  assign misalign = in_valid && (ld || st || ll || sc) && mis;
  assign start    = (state == IDLE) && in_valid && !mis
                 && (ld || st || ll || (sc && LLbit_i));
  assign sc_fail  = in_valid && sc && !LLbit_i && !mis;

  always_comb begin
    wstrb_nxt = 4'b1111;
    wdata_nxt = mem_store_data;
    unique case (sz)
      SZ_B: begin
        wstrb_nxt = 4'b0001 << mem_addr[1:0];
        wdata_nxt = {4{mem_store_data[7:0]}};
      end
      SZ_H: begin
        wstrb_nxt = mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {2{mem_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (dram.dram_ack) state_nxt = DONE;
      DONE:    if (!pause[4]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are loaded once at issue and held until the ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      dram.dram_req   <= 1'b0;
      dram.dram_we    <= 1'b0;
      dram.dram_addr  <= '0;
      dram.dram_wstrb <= '0;
      dram.dram_wdata <= '0;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      ll_q    <= 1'b0;
      sc_q    <= 1'b0;
      sx_q    <= 1'b0;
      sz_q    <= SZ_W;
      off_q   <= '0;
      rd_q    <= '0;
      rdata_q <= '0;
    end else if (start) begin
      dram.dram_req   <= 1'b1;
      dram.dram_we    <= st || sc;
      dram.dram_addr  <= {mem_addr[31:2], 2'b00};
      dram.dram_wstrb <= (st || sc) ? wstrb_nxt : 4'b0000;
      dram.dram_wdata <= (st || sc) ? wdata_nxt : 32'd0;
      ld_q  <= ld;
      st_q  <= st;
      ll_q  <= ll;
      sc_q  <= sc;
      sx_q  <= sx;
      sz_q  <= sz;
      off_q <= mem_addr[1:0];
      rd_q  <= ex_reg_write_addr;
    end else if ((state == BUSY) && dram.dram_ack) begin
      dram.dram_req <= 1'b0;
      rdata_q       <= dram.dram_rdata;
    end
  end

  assign shifted = rdata_q >> {off_q, 3'b000};
  assign lane_b  = shifted[7:0];
  assign lane_h  = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];

  always_comb begin
    ld_data = rdata_q;
    unique case (sz_q)
      SZ_B:    ld_data = sx_q ? {{24{lane_b[7]}}, lane_b} : {24'd0, lane_b};
      SZ_H:    ld_data = sx_q ? {{16{lane_h[15]}}, lane_h} : {16'd0, lane_h};
      default: ld_data = rdata_q;
    endcase
  end

  always_comb begin
    pause_request        = 1'b0;
    align_error          = 1'b0;
    mem_reg_write_data   = ex_reg_write_data;
    mem_reg_write_addr   = ex_reg_write_addr;
    mem_reg_write_en     = ex_reg_write_en;
    mem_LLbit_write_en   = 1'b0;
    mem_LLbit_write_data = 1'b0;
    unique case (state)
      IDLE: begin
        if (misalign) begin
          align_error      = 1'b1;
          mem_reg_write_en = 1'b0;
        end else if (start) begin
          pause_request    = 1'b1;
          mem_reg_write_en = 1'b0;
        end else if (sc_fail) begin
          mem_reg_write_data = 32'd0;
          mem_reg_write_en   = 1'b1;
`ifdef MEM_LLSC_EN
          mem_LLbit_write_en = 1'b1;
`endif
        end
      end
      BUSY: begin
        pause_request    = 1'b1;
        mem_reg_write_en = 1'b0;
      end
      DONE: begin
        mem_reg_write_data = sc_q ? 32'd1 : ld_data;
        mem_reg_write_addr = rd_q;
        mem_reg_write_en   = ld_q || ll_q || sc_q;
`ifdef MEM_LLSC_EN
        mem_LLbit_write_en   = ll_q || sc_q;
        mem_LLbit_write_data = ll_q;
`endif
      end
      default: ;
    endcase
  end

  logic unused_st_q;
  assign unused_st_q = st_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access.
// Covers loads, stores, alignment, LL/SC (or its NONE decode), DONE hold and reset.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  pause;
  logic        in_valid;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_store_data;
  logic [31:0] ex_d;
  logic [4:0]  ex_a;
  logic        ex_en;
  logic        llbit;
  logic        pause_request;
  logic        align_error;
  logic [31:0] wb_d;
  logic [4:0]  wb_a;
  logic        wb_en;
  logic        ll_we;
  logic        ll_d;

  int total = 0;
  int bad   = 0;

  mem_access_if dif ();

  mem_access dut (
    .clk                  (clk),
    .rst                  (rst),
    .pause                (pause),
    .in_valid             (in_valid),
    .mem_op               (mem_op),
    .mem_addr             (mem_addr),
    .mem_store_data       (mem_store_data),
    .ex_reg_write_data    (ex_d),
    .ex_reg_write_addr    (ex_a),
    .ex_reg_write_en      (ex_en),
    .LLbit_i              (llbit),
    .dram                 (dif),
    .pause_request        (pause_request),
    .align_error          (align_error),
    .mem_reg_write_data   (wb_d),
    .mem_reg_write_addr   (wb_a),
    .mem_reg_write_en     (wb_en),
    .mem_LLbit_write_en   (ll_we),
    .mem_LLbit_write_data (ll_d)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    in_valid = 1'b0;
    mem_op = 4'h0;
    mem_addr = '0;
    mem_store_data = '0;
    ex_d = '0;
    ex_a = '0;
    ex_en = 1'b0;
    llbit = 1'b0;
    pause = '0;
    dif.dram_ack = 1'b0;
    dif.dram_rdata = '0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    total++;
    if ({dif.dram_req, dif.dram_we, dif.dram_wstrb} !== 6'd0) begin
      bad++;
      $display("FAIL rst_req_we_strb got=%b exp=0",
               {dif.dram_req, dif.dram_we, dif.dram_wstrb});
    end
    total++;
    if ({dif.dram_addr, dif.dram_wdata} !== 64'd0) begin
      bad++;
      $display("FAIL rst_addr_wdata got=%h exp=0", {dif.dram_addr, dif.dram_wdata});
    end
    total++;
    if ({pause_request, align_error, wb_en, wb_d, ll_we} !== 36'd0) begin
      bad++;
      $display("FAIL rst_outputs got=%h exp=0",
               {pause_request, align_error, wb_en, wb_d, ll_we});
    end
  endtask

  task automatic test_passthrough;
    ex_d = 32'h1234_5678;
    ex_a = 5'd3;
    ex_en = 1'b1;
    dif.dram_ack = 1'b1;
    #1;
    total++;
    if ({wb_d, wb_a, wb_en, pause_request} !== {32'h1234_5678, 5'd3, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL pass_outputs got=%h/%0d/%b/%b exp=12345678/3/1/0",
               wb_d, wb_a, wb_en, pause_request);
    end
    tick();
    dif.dram_ack = 1'b0;
    #1;
    total++;
    if ({dif.dram_req, pause_request, wb_d} !== {1'b0, 1'b0, 32'h1234_5678}) begin
      bad++;
      $display("FAIL idle_ack_ignored got=%b/%b/%h exp=0/0/12345678",
               dif.dram_req, pause_request, wb_d);
    end
    idle_inputs();
  endtask

  task automatic test_ld_b;
    in_valid = 1'b1;
    mem_op = 4'h1;
    mem_addr = 32'h0000_1003;
    ex_a = 5'd5;
    ex_en = 1'b1;
    ex_d = 32'h0000_AAAA;
    #1;
    total++;
    if ({pause_request, wb_en} !== 2'b10) begin
      bad++;
      $display("FAIL ldb_c0 got=pause%b/en%b exp=pause1/en0", pause_request, wb_en);
    end
    tick();
    total++;
    if ({dif.dram_req, dif.dram_we, dif.dram_addr, pause_request}
        !== {1'b1, 1'b0, 32'h0000_1000, 1'b1}) begin
      bad++;
      $display("FAIL ldb_c1 got=req%b we%b addr%h pause%b exp=req1 we0 addr00001000 pause1",
               dif.dram_req, dif.dram_we, dif.dram_addr, pause_request);
    end
    dif.dram_ack = 1'b1;
    dif.dram_rdata = 32'h80FF_1234;
    tick();
    dif.dram_ack = 1'b0;
    dif.dram_rdata = '0;
    in_valid = 1'b0;
    #1;
    total++;
    if ({dif.dram_req, pause_request} !== 2'b00) begin
      bad++;
      $display("FAIL ldb_c2_ctrl got=req%b pause%b exp=req0 pause0",
               dif.dram_req, pause_request);
    end
    total++;
    if ({wb_d, wb_a, wb_en} !== {32'hFFFF_FF80, 5'd5, 1'b1}) begin
      bad++;
      $display("FAIL ldb_result got=%h/%0d/%b exp=ffffff80/5/1", wb_d, wb_a, wb_en);
    end
    tick();
    total++;
    if ({wb_d, pause_request} !== {32'h0000_AAAA, 1'b0}) begin
      bad++;
      $display("FAIL ldb_back_idle got=%h/%b exp=0000aaaa/0", wb_d, pause_request);
    end
    idle_inputs();
  endtask

  task automatic test_st_h;
    in_valid = 1'b1;
    mem_op = 4'h7;
    mem_addr = 32'h0000_2002;
    mem_store_data = 32'h0000_ABCD;
    #1;
    total++;
    if (pause_request !== 1'b1) begin
      bad++;
      $display("FAIL sth_c0_pause got=%b exp=1", pause_request);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dif.dram_ack = 1'b1;
      #1;
      total++;
      if ({dif.dram_req, dif.dram_we, dif.dram_wstrb, dif.dram_addr, dif.dram_wdata, pause_request}
          !== {1'b1, 1'b1, 4'b1100, 32'h0000_2000, 32'hABCD_ABCD, 1'b1}) begin
        bad++;
        $display("FAIL sth_busy%0d got=req%b we%b strb%b addr%h wdata%h pause%b exp=1 1 1100 00002000 abcdabcd 1",
                 i, dif.dram_req, dif.dram_we, dif.dram_wstrb, dif.dram_addr,
                 dif.dram_wdata, pause_request);
      end
      tick();
    end
    dif.dram_ack = 1'b0;
    in_valid = 1'b0;
    #1;
    total++;
    if ({wb_en, pause_request, dif.dram_req} !== 3'b000) begin
      bad++;
      $display("FAIL sth_done got=en%b pause%b req%b exp=0 0 0",
               wb_en, pause_request, dif.dram_req);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_misalign;
    in_valid = 1'b1;
    mem_op = 4'h3;
    mem_addr = 32'h0000_3001;
    ex_en = 1'b1;
    ex_a = 5'd6;
    #1;
    total++;
    if ({align_error, pause_request, wb_en} !== 3'b100) begin
      bad++;
      $display("FAIL mis_c0 got=err%b pause%b en%b exp=1 0 0",
               align_error, pause_request, wb_en);
    end
    tick();
    total++;
    if ({dif.dram_req, pause_request} !== 2'b00) begin
      bad++;
      $display("FAIL mis_noreq got=req%b pause%b exp=0 0", dif.dram_req, pause_request);
    end
    mem_op = 4'h2;
    mem_addr = 32'h0000_3002;
    #1;
    total++;
    if ({align_error, pause_request} !== 2'b01) begin
      bad++;
      $display("FAIL mis_h_ok got=err%b pause%b exp=0 1", align_error, pause_request);
    end
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

`ifdef MEM_LLSC_EN
  task automatic test_llsc;
    in_valid = 1'b1;
    mem_op = 4'h9;
    mem_addr = 32'h0000_4000;
    ex_a = 5'd7;
    ex_en = 1'b1;
    tick();
    dif.dram_ack = 1'b1;
    dif.dram_rdata = 32'h1122_3344;
    tick();
    dif.dram_ack = 1'b0;
    in_valid = 1'b0;
    #1;
    total++;
    if ({wb_d, wb_a, wb_en, ll_we, ll_d} !== {32'h1122_3344, 5'd7, 1'b1, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL ll_done got=%h/%0d/%b/%b/%b exp=11223344/7/1/1/1",
               wb_d, wb_a, wb_en, ll_we, ll_d);
    end
    tick();
    in_valid = 1'b1;
    mem_op = 4'hA;
    llbit = 1'b1;
    mem_store_data = 32'h0000_0055;
    ex_a = 5'd8;
    #1;
    total++;
    if (pause_request !== 1'b1) begin
      bad++;
      $display("FAIL sc1_pause got=%b exp=1", pause_request);
    end
    tick();
    total++;
    if ({dif.dram_req, dif.dram_we, dif.dram_wstrb, dif.dram_wdata}
        !== {1'b1, 1'b1, 4'b1111, 32'h0000_0055}) begin
      bad++;
      $display("FAIL sc1_req got=req%b we%b strb%b wdata%h exp=1 1 1111 00000055",
               dif.dram_req, dif.dram_we, dif.dram_wstrb, dif.dram_wdata);
    end
    dif.dram_ack = 1'b1;
    tick();
    dif.dram_ack = 1'b0;
    in_valid = 1'b0;
    #1;
    total++;
    if ({wb_d, wb_a, wb_en, ll_we, ll_d} !== {32'd1, 5'd8, 1'b1, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL sc1_done got=%h/%0d/%b/%b/%b exp=00000001/8/1/1/0",
               wb_d, wb_a, wb_en, ll_we, ll_d);
    end
    tick();
    in_valid = 1'b1;
    llbit = 1'b0;
    ex_d = 32'h0000_0099;
    #1;
    total++;
    if ({wb_d, wb_en, ll_we, ll_d, pause_request} !== {32'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL sc0_idle got=%h/%b/%b/%b/%b exp=00000000/1/1/0/0",
               wb_d, wb_en, ll_we, ll_d, pause_request);
    end
    tick();
    total++;
    if (dif.dram_req !== 1'b0) begin
      bad++;
      $display("FAIL sc0_noreq got=%b exp=0", dif.dram_req);
    end
    idle_inputs();
  endtask
`else
  task automatic test_llsc_off;
    in_valid = 1'b1;
    mem_op = 4'h9;
    mem_addr = 32'h0000_4000;
    ex_d = 32'h0000_0077;
    ex_a = 5'd4;
    ex_en = 1'b1;
    llbit = 1'b1;
    #1;
    total++;
    if ({wb_d, wb_en, ll_we, ll_d, pause_request} !== {32'h77, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL ll_off got=%h/%b/%b/%b/%b exp=00000077/1/0/0/0",
               wb_d, wb_en, ll_we, ll_d, pause_request);
    end
    mem_op = 4'hA;
    #1;
    total++;
    if ({wb_d, wb_en, ll_we, pause_request} !== {32'h77, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL sc_off got=%h/%b/%b/%b exp=00000077/1/0/0",
               wb_d, wb_en, ll_we, pause_request);
    end
    tick();
    total++;
    if (dif.dram_req !== 1'b0) begin
      bad++;
      $display("FAIL llsc_off_noreq got=%b exp=0", dif.dram_req);
    end
    idle_inputs();
  endtask
`endif

  task automatic test_ld_hu_hold;
    in_valid = 1'b1;
    mem_op = 4'h5;
    mem_addr = 32'h0000_5002;
    ex_a = 5'd9;
    ex_en = 1'b1;
    tick();
    dif.dram_ack = 1'b1;
    dif.dram_rdata = 32'h9876_0000;
    pause = 6'b01_0000;
    tick();
    dif.dram_ack = 1'b0;
    dif.dram_rdata = '0;
    in_valid = 1'b0;
    ex_d = 32'h0000_0042;
    ex_a = 5'd1;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if ({wb_d, wb_a, wb_en, pause_request} !== {32'h0000_9876, 5'd9, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL hu_hold%0d got=%h/%0d/%b/%b exp=00009876/9/1/0",
                 i, wb_d, wb_a, wb_en, pause_request);
      end
      tick();
    end
    pause = '0;
    #1;
    total++;
    if (wb_d !== 32'h0000_9876) begin
      bad++;
      $display("FAIL hu_release got=%h exp=00009876", wb_d);
    end
    tick();
    total++;
    if ({wb_d, wb_a} !== {32'h0000_0042, 5'd1}) begin
      bad++;
      $display("FAIL hu_idle got=%h/%0d exp=00000042/1", wb_d, wb_a);
    end
    idle_inputs();
  endtask

  task automatic test_reset_busy;
    in_valid = 1'b1;
    mem_op = 4'h3;
    mem_addr = 32'h0000_6000;
    ex_a = 5'd10;
    ex_en = 1'b1;
    tick();
    total++;
    if (dif.dram_req !== 1'b1) begin
      bad++;
      $display("FAIL rb_busy_req got=%b exp=1", dif.dram_req);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    #1;
    total++;
    if ({dif.dram_req, pause_request} !== 2'b00) begin
      bad++;
      $display("FAIL rb_after_rst got=req%b pause%b exp=0 0", dif.dram_req, pause_request);
    end
    dif.dram_ack = 1'b1;
    dif.dram_rdata = 32'hDEAD_BEEF;
    tick();
    dif.dram_ack = 1'b0;
    #1;
    total++;
    if ({wb_en, wb_d, pause_request, dif.dram_req} !== {1'b0, 32'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL rb_late_ack got=en%b d%h pause%b req%b exp=0 00000000 0 0",
               wb_en, wb_d, pause_request, dif.dram_req);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_ld_b();
    test_st_h();
    test_misalign();
`ifdef MEM_LLSC_EN
    test_llsc();
`else
    test_llsc_off();
`endif
    test_ld_hu_hold();
    test_reset_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access pipeline stage between the ex_mem register and the mem_wb register. It decodes the load/store/LL/SC operation, runs a req/ack transaction on the data-memory port, and holds the pipeline with a pause request while the transaction is outstanding. It then presents the aligned, extended load result and the LLbit update to mem_wb for one accepted cycle.

## Interface
- No parameters.
- clk  in  1  pipeline clock
- rst  in  1  reset (synchronous, active-high)
- pause  in  6  global pause vector; bit 4 = mem_wb hold
- in_valid  in  1  ex_mem slot holds a valid instruction
- mem_op  in  4  0 NONE, 1 LD_B, 2 LD_H, 3 LD_W, 4 LD_BU, 5 LD_HU, 6 ST_B, 7 ST_H, 8 ST_W, 9 LL_W, A SC_W, others = NONE
- mem_addr  in  32  effective address
- mem_store_data  in  32  rk/rd store data
- ex_reg_write_data / ex_reg_write_addr / ex_reg_write_en  in  32/5/1  ALU result path
- LLbit_i  in  1  current LLbit (forwarded)
- dram_req / dram_we / dram_addr / dram_wstrb / dram_wdata  out  1/1/32/4/32  registered memory request; dram_addr word-aligned
- dram_ack  in  1  one-cycle completion pulse; dram_rdata (in, 32) valid with it
- pause_request  out  1  to pause controller
- align_error  out  1  misaligned access detected this cycle
- mem_reg_write_data / mem_reg_write_addr / mem_reg_write_en  out  32/5/1  to mem_wb
- mem_LLbit_write_en / mem_LLbit_write_data  out  1/1  to mem_wb

## Operation
- FSM: IDLE, BUSY, DONE.
- IDLE, access op with in_valid=1 and aligned address:
  - pause_request=1.
  - Register the request (dram_req=1 from next cycle).
  - Capture op, addr[1:0], and rd address.
  - Go to BUSY.
- IDLE, NONE / in_valid=0:
  - Combinational passthrough of ex_* to mem_*.
  - LLbit_write_en=0, no pause.
- BUSY:
  - dram_req and all request fields hold stable until dram_ack.
  - On ack: capture dram_rdata, drop dram_req at the next edge, go to DONE.
  - pause_request=1 throughout BUSY.
- DONE:
  - pause_request=0.
  - Outputs are driven from the captured result.
  - Go to IDLE when pause[4]=0; otherwise stay in DONE with outputs held.
- Alignment: H needs addr[0]=0; W/LL/SC need addr[1:0]=0.
  - Misaligned: no transaction, align_error=1, mem_reg_write_en=0, LLbit_write_en=0, no pause.
- Store formatting:
  - B: wdata={4{d[7:0]}}, wstrb=1<<addr[1:0].
  - H: wdata={2{d[15:0]}}, wstrb=addr[1]?1100:0011.
  - W: wstrb=1111.
- Load extraction: select the lane by captured addr[1:0]; sign-extend for LD_B/LD_H, zero-extend for LD_BU/LD_HU.
- Register write enable:
  - Stores: mem_reg_write_en=0.
  - Loads and LL: mem_reg_write_en=1, using the captured rd address.
- LL_W: word load; LLbit_write_en=1, data=1.
- SC_W, LLbit_i=1: word store; rd←1; LLbit_write_en=1, data=0.
- SC_W, LLbit_i=0: no transaction, no pause; rd←0; LLbit_write_en=1, data=0.

## Timing
- Reset values: state=IDLE; dram_req, dram_we, dram_addr, dram_wstrb, dram_wdata all 0; captured data 0.
- Combinational outputs in IDLE follow their inputs. With in_valid=0 they are all 0 except the passthrough values.
- Minimum access latency (load or store, ack in the first BUSY cycle):
  - c0: IDLE, pause.
  - c1: BUSY, req, ack.
  - c2: DONE, result valid.
  - mem_wb captures at the end of c2: 2 pause cycles.
- dram_ack in IDLE or DONE is ignored.
- Reset during BUSY:
  - Next state is IDLE and dram_req=0.
  - The memory side shares rst; a late ack is ignored.
- Each request produces exactly one ack. A new request is never issued in the cycle after DONE for the same instruction, because ex_mem has already advanced.

## Configuration
- MEM_LLSC_EN defined: LL_W/SC_W behave as above.
- MEM_LLSC_EN undefined:
  - LL_W and SC_W decode as NONE (ALU passthrough).
  - mem_LLbit_write_en and mem_LLbit_write_data are tied 0.
  - LLbit_i is unused.

## Test plan
- LD_B, addr=0x1003, word 0x80FF_1234 at 0x1000, ack on first BUSY cycle → pause for 2 cycles; DONE data=0xFFFF_FF80, write_en=1.
- ST_H, addr=0x2002, data=0x0000_ABCD, ack delayed 3 cycles → dram_wdata=0xABCD_ABCD, wstrb=1100, dram_addr=0x2000; req stable for 4 cycles; write_en=0.
- LD_W, addr=0x3001 → align_error=1, no dram_req, no pause, write_en=0.
- LL_W at 0x4000 → rd=word, LLbit_we=1, data=1. Then SC_W with LLbit_i=1 → store issued, rd=1, LLbit cleared. Then SC_W with LLbit_i=0 → no req, rd=0.
- LD_HU at 0x5002 returning 0x9876_0000, with pause[4]=1 for 2 cycles in DONE → outputs hold 0x0000_9876 until pause[4]=0, then IDLE.
- rst asserted mid-BUSY → next cycle state=IDLE, dram_req=0; a subsequent ack produces no output.
